// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: result payload and issue-select encoding.
package wb_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       value;
  } wb_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU,
    SEL_LD,
    SEL_KILL
  } sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO with a per-entry live bit; entries whose rd matches kill_rd_i
// are marked dead in place and later popped without producing a writeback.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  wb_t                   push_data_i,
  input  logic                  pop_i,
  input  logic                  kill_en_i,
  input  logic [REG_ADDR_W-1:0] kill_rd_i,
  output wb_t                   head_o,
  output logic                  head_killed_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_t              mem_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Kill marks matching entries dead; a push always writes a fresh live entry.
  always_comb begin
    live_d = live_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (kill_en_i && (mem_q[i].rd == kill_rd_i)) live_d[i] = 1'b0;
    end
    if (push_i) live_d[wr_ptr_q] = 1'b1;
    wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      live_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      live_q   <= live_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o        = mem_q[rd_ptr_q];
  assign head_killed_o = !live_q[rd_ptr_q];
  assign full_o        = (count_q == CNT_W'(DEPTH));
  assign empty_o       = (count_q == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and load results onto decode's EX0/EX3 writeback ports, one per cycle.
// Optional feature macro WB_BYPASS_EN: loads into an idle arbiter skip the FIFO.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_alu_valid,
  input  logic [REG_ADDR_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]       i_alu_value,
  output logic                  o_alu_ready,
  input  logic                  i_ld_valid,
  input  logic [REG_ADDR_W-1:0] i_ld_rd,
  input  logic [XLEN-1:0]       i_ld_value,
  output logic                  o_ld_ready,
  output logic                  o_EX0_wb_valid,
  output logic [REG_ADDR_W-1:0] o_EX0_wb_rd,
  output logic [XLEN-1:0]       o_EX0_wb_value,
  output logic                  o_EX3_wb_valid,
  output logic [REG_ADDR_W-1:0] o_EX3_wb_rd,
  output logic [XLEN-1:0]       o_EX3_wb_value,
  output logic                  o_busy
);

  localparam int unsigned     SCNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STARVE_LIMIT);

  wb_t               fifo_head;
  logic              fifo_head_killed, fifo_full, fifo_empty;
  logic              push, pop, bypass, starve, alu_live, ld_keep;
  sel_e              sel;
  logic [SCNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic              ex0_valid_q, ex0_valid_d, ex3_valid_q, ex3_valid_d;
  wb_t               ex0_q, ex0_d, ex3_q, ex3_d;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i         (i_clk),
    .rst_ni        (i_rst_n),
    .push_i        (push),
    .push_data_i   ({i_ld_rd, i_ld_value}),
    .pop_i         (pop),
    .kill_en_i     (alu_live),
    .kill_rd_i     (i_alu_rd),
    .head_o        (fifo_head),
    .head_killed_o (fifo_head_killed),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty)
  );

  // ALU results are younger than any buffered or same-cycle load, hence the kill/drop on rd match.
  always_comb begin
    sel          = SEL_NONE;
    bypass       = 1'b0;
    ex0_valid_d  = 1'b0;
    ex3_valid_d  = 1'b0;
    ex0_d        = ex0_q;
    ex3_d        = ex3_q;
    starve       = !fifo_empty && (starve_cnt_q >= SCNT_MAX);
    alu_live     = i_alu_valid && !starve && (i_alu_rd != '0);
    ld_keep      = i_ld_valid && !fifo_full && (i_ld_rd != '0)
                   && !(alu_live && (i_alu_rd == i_ld_rd));

    if (starve || (!alu_live && !fifo_empty)) begin
      sel = fifo_head_killed ? SEL_KILL : SEL_LD;
    end else if (alu_live) begin
      sel = SEL_ALU;
    end

`ifdef WB_BYPASS_EN
    bypass = fifo_empty && !i_alu_valid && ld_keep;
`else
    bypass = 1'b0;
`endif

    push = ld_keep && !bypass;
    pop  = (sel == SEL_LD) || (sel == SEL_KILL);

    if (sel == SEL_ALU) begin
      ex0_valid_d = 1'b1;
      ex0_d       = '{rd: i_alu_rd, value: i_alu_value};
    end
    if (sel == SEL_LD) begin
      ex3_valid_d = 1'b1;
      ex3_d       = fifo_head;
    end else if (bypass) begin
      ex3_valid_d = 1'b1;
      ex3_d       = '{rd: i_ld_rd, value: i_ld_value};
    end

    if (pop || fifo_empty)           starve_cnt_d = '0;
    else if (starve_cnt_q >= SCNT_MAX) starve_cnt_d = SCNT_MAX;
    else                             starve_cnt_d = starve_cnt_q + SCNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt_q <= '0;
      ex0_valid_q  <= 1'b0;
      ex3_valid_q  <= 1'b0;
      ex0_q        <= '0;
      ex3_q        <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      ex0_valid_q  <= ex0_valid_d;
      ex3_valid_q  <= ex3_valid_d;
      ex0_q        <= ex0_d;
      ex3_q        <= ex3_d;
    end
  end

  assign o_alu_ready    = !starve;
  assign o_ld_ready     = !fifo_full;
  assign o_EX0_wb_valid = ex0_valid_q;
  assign o_EX0_wb_rd    = ex0_q.rd;
  assign o_EX0_wb_value = ex0_q.value;
  assign o_EX3_wb_valid = ex3_valid_q;
  assign o_EX3_wb_rd    = ex3_q.rd;
  assign o_EX3_wb_value = ex3_q.value;
  assign o_busy         = !fifo_empty || ex0_valid_q || ex3_valid_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_wb_arbiter;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned STARVE_LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, ld_valid;
  logic [4:0]  alu_rd, ld_rd;
  logic [63:0] alu_value, ld_value;
  logic        alu_ready, ld_ready;
  logic        ex0_valid, ex3_valid, busy;
  logic [4:0]  ex0_rd, ex3_rd;
  logic [63:0] ex0_value, ex3_value;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_alu_valid    (alu_valid),
    .i_alu_rd       (alu_rd),
    .i_alu_value    (alu_value),
    .o_alu_ready    (alu_ready),
    .i_ld_valid     (ld_valid),
    .i_ld_rd        (ld_rd),
    .i_ld_value     (ld_value),
    .o_ld_ready     (ld_ready),
    .o_EX0_wb_valid (ex0_valid),
    .o_EX0_wb_rd    (ex0_rd),
    .o_EX0_wb_value (ex0_value),
    .o_EX3_wb_valid (ex3_valid),
    .o_EX3_wb_rd    (ex3_rd),
    .o_EX3_wb_value (ex3_value),
    .o_busy         (busy)
  );

  // Reference model: buffered loads in program order, each with a still-live flag.
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] value;
    bit          alive;
  } ment_t;

  ment_t       mq[$];
  int          m_scnt;
  logic        m_e0v, m_e3v;
  logic [4:0]  m_e0rd, m_e3rd;
  logic [63:0] m_e0val, m_e3val;

  typedef struct {
    int av; int ard; longint unsigned aval;
    int lv; int lrd; longint unsigned lval;
    int e0v; int e0rd; longint unsigned e0val;
    int e3v; int e3rd; longint unsigned e3val;
    int busy; int ardy;
  } vec_t;

  vec_t tbl[16];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_scnt  = 0;
    m_e0v   = 1'b0; m_e3v   = 1'b0;
    m_e0rd  = '0;   m_e3rd  = '0;
    m_e0val = '0;   m_e3val = '0;
  endfunction

  task automatic model_step(input int av, input int ard, input longint unsigned aval,
                            input int lv, input int lrd, input longint unsigned lval);
    bit    empty0, starve, alu_live, ld_keep, bypass, popped;
    ment_t e;
    empty0   = (mq.size() == 0);
    starve   = !empty0 && (m_scnt >= int'(STARVE_LIMIT));
    alu_live = (av != 0) && !starve && (ard != 0);
    ld_keep  = (lv != 0) && (mq.size() < int'(DEPTH)) && (lrd != 0)
               && !(alu_live && (ard == lrd));
    bypass   = 1'b0;
    popped   = 1'b0;
`ifdef WB_BYPASS_EN
    bypass = empty0 && (av == 0) && ld_keep;
`endif
    m_e0v = 1'b0;
    m_e3v = 1'b0;
    if (starve || (!alu_live && !empty0)) begin
      e = mq.pop_front();
      popped = 1'b1;
      if (e.alive) begin
        m_e3v = 1'b1; m_e3rd = e.rd; m_e3val = e.value;
      end
    end else if (alu_live) begin
      m_e0v = 1'b1; m_e0rd = 5'(ard); m_e0val = aval;
    end else if (bypass) begin
      m_e3v = 1'b1; m_e3rd = 5'(lrd); m_e3val = lval;
    end
    if (alu_live) begin
      foreach (mq[i]) if (mq[i].rd == 5'(ard)) mq[i].alive = 1'b0;
    end
    if (ld_keep && !bypass) mq.push_back('{rd: 5'(lrd), value: lval, alive: 1'b1});
    if (popped || empty0) m_scnt = 0;
    else m_scnt = (m_scnt + 1 > int'(STARVE_LIMIT)) ? int'(STARVE_LIMIT) : m_scnt + 1;
  endtask

  function automatic void check_outputs(string tag);
    bit m_alu_rdy, m_ld_rdy, m_busy;
    m_alu_rdy = !((mq.size() != 0) && (m_scnt >= int'(STARVE_LIMIT)));
    m_ld_rdy  = (mq.size() != int'(DEPTH));
    m_busy    = (mq.size() != 0) || m_e0v || m_e3v;
    chk({tag, "/ex0_valid"}, 64'(ex0_valid), 64'(m_e0v));
    chk({tag, "/ex0_rd"},    64'(ex0_rd),    64'(m_e0rd));
    chk({tag, "/ex0_value"}, ex0_value,      m_e0val);
    chk({tag, "/ex3_valid"}, 64'(ex3_valid), 64'(m_e3v));
    chk({tag, "/ex3_rd"},    64'(ex3_rd),    64'(m_e3rd));
    chk({tag, "/ex3_value"}, ex3_value,      m_e3val);
    chk({tag, "/busy"},      64'(busy),      64'(m_busy));
    chk({tag, "/alu_ready"}, 64'(alu_ready), 64'(m_alu_rdy));
    chk({tag, "/ld_ready"},  64'(ld_ready),  64'(m_ld_rdy));
  endfunction

  // One clock: drive inputs, advance the model, clock, compare #1 after the edge.
  task automatic cycle(input int av, input int ard, input longint unsigned aval,
                       input int lv, input int lrd, input longint unsigned lval,
                       output bit ld_rdy_pre);
    alu_valid  = (av != 0);
    alu_rd     = 5'(ard);
    alu_value  = aval;
    ld_valid   = (lv != 0);
    ld_rd      = 5'(lrd);
    ld_value   = lval;
    ld_rdy_pre = ld_ready;
    model_step(av, ard, aval, lv, lrd, lval);
    @(posedge clk);
    #1;
    check_outputs("model");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit              rdy;
    int              k, lvv;
    bit              saw_low, first;
    int              got[$];
    int              av, ard, lv, lrd;
    longint unsigned aval, lval;

    tbl[0]  = '{1,5,'h1234, 0,0,0,     1,5,'h1234, 0,0,0,    1,1};
    tbl[1]  = '{0,0,0,      0,0,0,     0,5,'h1234, 0,0,0,    0,1};
    tbl[2]  = '{1,0,'h99,   0,0,0,     0,5,'h1234, 0,0,0,    0,1};
    tbl[3]  = '{1,1,'h11,   1,2,'hAA,  1,1,'h11,   0,0,0,    1,1};
    tbl[4]  = '{1,1,'h12,   0,0,0,     1,1,'h12,   0,0,0,    1,1};
    tbl[5]  = '{1,1,'h13,   0,0,0,     1,1,'h13,   0,0,0,    1,1};
    tbl[6]  = '{1,1,'h14,   0,0,0,     1,1,'h14,   0,0,0,    1,0};
    tbl[7]  = '{1,1,'h15,   0,0,0,     0,1,'h14,   1,2,'hAA, 1,1};
    tbl[8]  = '{1,1,'h15,   0,0,0,     1,1,'h15,   0,2,'hAA, 1,1};
    tbl[9]  = '{1,4,'h40,   1,7,1,     1,4,'h40,   0,2,'hAA, 1,1};
    tbl[10] = '{1,7,2,      0,0,0,     1,7,2,      0,2,'hAA, 1,1};
    tbl[11] = '{0,0,0,      0,0,0,     0,7,2,      0,2,'hAA, 0,1};
    tbl[12] = '{1,7,3,      1,7,4,     1,7,3,      0,2,'hAA, 1,1};
    tbl[13] = '{0,0,0,      0,0,0,     0,7,3,      0,2,'hAA, 0,1};
    tbl[14] = '{1,6,6,      1,0,'h77,  1,6,6,      0,2,'hAA, 1,1};
    tbl[15] = '{0,0,0,      0,0,0,     0,6,6,      0,2,'hAA, 0,1};

    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_value = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_value  = '0;
    model_reset();
    #12;
    chk("reset/ex0_valid", 64'(ex0_valid), 64'(0));
    chk("reset/ex3_valid", 64'(ex3_valid), 64'(0));
    chk("reset/ex3_value", ex3_value,      64'(0));
    chk("reset/busy",      64'(busy),      64'(0));
    chk("reset/alu_ready", 64'(alu_ready), 64'(1));
    chk("reset/ld_ready",  64'(ld_ready),  64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors: ALU-only, x0, starvation, kill, same-cycle drop.
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].av, tbl[i].ard, tbl[i].aval, tbl[i].lv, tbl[i].lrd, tbl[i].lval, rdy);
      chk($sformatf("tbl%0d/ex0_valid", i), 64'(ex0_valid), 64'(tbl[i].e0v));
      chk($sformatf("tbl%0d/ex0_rd", i),    64'(ex0_rd),    64'(tbl[i].e0rd));
      chk($sformatf("tbl%0d/ex0_value", i), ex0_value,      tbl[i].e0val);
      chk($sformatf("tbl%0d/ex3_valid", i), 64'(ex3_valid), 64'(tbl[i].e3v));
      chk($sformatf("tbl%0d/ex3_rd", i),    64'(ex3_rd),    64'(tbl[i].e3rd));
      chk($sformatf("tbl%0d/ex3_value", i), ex3_value,      tbl[i].e3val);
      chk($sformatf("tbl%0d/busy", i),      64'(busy),      64'(tbl[i].busy));
      chk($sformatf("tbl%0d/alu_ready", i), 64'(alu_ready), 64'(tbl[i].ardy));
    end

    // Bypass latency: one edge with the feature, two without.
    cycle(0, 0, 0, 1, 3, 'h55, rdy);
`ifdef WB_BYPASS_EN
    chk("bypass/edge0_valid", 64'(ex3_valid), 64'(1));
    chk("bypass/edge0_rd",    64'(ex3_rd),    64'(3));
`else
    chk("bypass/edge0_valid", 64'(ex3_valid), 64'(0));
`endif
    cycle(0, 0, 0, 0, 0, 0, rdy);
`ifdef WB_BYPASS_EN
    chk("bypass/edge1_valid", 64'(ex3_valid), 64'(0));
`else
    chk("bypass/edge1_valid", 64'(ex3_valid), 64'(1));
    chk("bypass/edge1_rd",    64'(ex3_rd),    64'(3));
    chk("bypass/edge1_value", ex3_value,      64'h55);
`endif
    cycle(0, 0, 0, 0, 0, 0, rdy);

    // Full FIFO under a saturating ALU stream: 5 loads must all drain in order.
    k = 0; saw_low = 1'b0; first = 1'b1;
    got.delete();
    for (int c = 0; c < 40 && got.size() < 5; c++) begin
      lvv = (k < 5) ? 1 : 0;
      if (k == 4 && !ld_ready) saw_low = 1'b1;
      cycle(1, 1, 64'('h100 + c), lvv, 10 + k, 64'('h500 + k), rdy);
      if (ex3_valid) begin
        if (first) begin
          chk("full/ld_ready_after_pop", 64'(ld_ready), 64'(1));
          first = 1'b0;
        end
        got.push_back(int'(ex3_rd));
      end
      if (lvv != 0 && rdy) k++;
    end
    chk("full/fifth_blocked", 64'(saw_low), 64'(1));
    chk("full/count", 64'(got.size()), 64'(5));
    for (int i = 0; i < 5; i++)
      chk($sformatf("full/order%0d", i), 64'((i < got.size()) ? got[i] : -1), 64'(10 + i));
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, rdy);

    // Reset with three loads pending: nothing may be written back afterwards.
    for (int i = 0; i < 3; i++) cycle(1, 1, 64'('h200 + i), 1, 20 + i, 64'('h300 + i), rdy);
    #1;
    rst_n = 1'b0;
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    #1;
    chk("rst_pend/ex0_valid", 64'(ex0_valid), 64'(0));
    chk("rst_pend/ex3_valid", 64'(ex3_valid), 64'(0));
    chk("rst_pend/ex0_value", ex0_value,      64'(0));
    chk("rst_pend/busy",      64'(busy),      64'(0));
    chk("rst_pend/alu_ready", 64'(alu_ready), 64'(1));
    chk("rst_pend/ld_ready",  64'(ld_ready),  64'(1));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0, 0, 0, rdy);
      chk("rst_pend/no_wb", 64'(ex3_valid), 64'(0));
    end

    // Random traffic over a small rd range to exercise kills, x0 and starvation.
    for (int i = 0; i < 300; i++) begin
      av   = ($urandom_range(0, 9) < 6) ? 1 : 0;
      ard  = int'($urandom_range(0, 4));
      aval = {$urandom, $urandom};
      lv   = int'($urandom_range(0, 1));
      lrd  = int'($urandom_range(0, 4));
      lval = {$urandom, $urandom};
      cycle(av, ard, aval, lv, lrd, lval, rdy);
      chk("rand/mutex", 64'(ex0_valid && ex3_valid), 64'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
